// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// alu_arbiter -- round-robin sharing of one combinational ALU among NREQ
// requesters, with a single registered response slot.   Revision: 1.0
// ============================================================================
module alu_arbiter #(
  parameter int NREQ = 2,
  parameter int TAGW = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*32-1:0]   req_a,
  input  logic [NREQ*32-1:0]   req_b,
  input  logic [NREQ*4-1:0]    req_op,
  input  logic [NREQ*TAGW-1:0] req_tag,
  output logic [31:0]          alu_a,
  output logic [31:0]          alu_b,
  output logic [3:0]           alu_op,
  input  logic [31:0]          alu_result,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [31:0]          rsp_result,
  output logic [TAGW-1:0]      rsp_tag
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] last_grant;
  logic [PW-1:0] grant;
  logic [PW-1:0] cand;
  logic          found;
  logic          rsp_fire;
  logic          slot_free;
  logic          accept;

  // Search starts one past the previous winner, so grants rotate.
  always_comb begin
    grant = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = PW'((int'(last_grant) + k) % NREQ);
      if (!found && req_valid[cand]) begin
        grant = cand;
        found = 1'b1;
      end
    end
  end

  assign rsp_fire  = |(rsp_valid & rsp_ready);
  assign slot_free = (rsp_valid == '0) || rsp_fire;
  assign accept    = slot_free && found && !reset;
  assign req_ready = accept ? (NREQ'(1) << grant) : '0;

  // The ALU follows the would-be winner even when the slot is busy.
  assign alu_a  = req_a[int'(grant)*32 +: 32];
  assign alu_b  = req_b[int'(grant)*32 +: 32];
  assign alu_op = req_op[int'(grant)*4 +: 4];

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid  <= '0;
      rsp_result <= '0;
      rsp_tag    <= '0;
      last_grant <= PW'(NREQ - 1);
    end else if (accept) begin
      rsp_result <= alu_result;
      rsp_tag    <= req_tag[int'(grant)*TAGW +: TAGW];
      rsp_valid  <= NREQ'(1) << grant;
      last_grant <= grant;
    end else if (rsp_fire) begin
      rsp_valid  <= '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// tb_alu_arbiter -- directed scenarios plus randomized traffic against a
// behavioural model of the arbiter and an external ALU.
module tb_alu_arbiter;
  localparam int NREQ = 2;
  localparam int TAGW = 4;
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_XOR = 4'd4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NREQ*32-1:0]   req_a, req_b;
  logic [NREQ*4-1:0]    req_op;
  logic [NREQ*TAGW-1:0] req_tag;
  logic [31:0]          alu_a, alu_b, alu_result, rsp_result;
  logic [3:0]           alu_op;
  logic [TAGW-1:0]      rsp_tag;
  int checks = 0;
  int errors = 0;

  alu_arbiter #(.NREQ(NREQ), .TAGW(TAGW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_tag(req_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_tag(rsp_tag)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << b[4:0];
      4'd6: return a >> b[4:0];
      default: return a;
    endcase
  endfunction

  always_comb alu_result = alu_f(alu_op, alu_a, alu_b);

  // Round-robin pick: first valid requester after `last`, or -1.
  function automatic int pick(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++)
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op, input logic [TAGW-1:0] tag);
    req_valid[i] = v;
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
    req_op[i*4 +: 4] = op;
    req_tag[i*TAGW +: TAGW] = tag;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    req_valid = '1;
    rsp_ready = '1;
    req_a = '0; req_b = '0; req_op = '0; req_tag = '0;
    tick();
    #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready got %b expected 00", req_ready); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got %b expected 00", rsp_valid); end
    checks++; if (rsp_result !== 32'd0 || rsp_tag !== 4'd0) begin errors++; $display("FAIL reset_rsp_data got %h/%h expected 0/0", rsp_result, rsp_tag); end
    req_valid = '0;
    reset = 1'b0;
  endtask

  task automatic test_single;
    set_req(0, 1'b1, 32'd5, 32'd7, OP_ADD, 4'd3);
    rsp_ready = 2'b01;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready got %b expected 01", req_ready); end
    checks++; if (alu_a !== 32'd5 || alu_b !== 32'd7) begin errors++; $display("FAIL single_alu got %0d,%0d expected 5,7", alu_a, alu_b); end
    tick();
    req_valid = '0;
    checks++; if (rsp_valid !== 2'b01 || rsp_result !== 32'd12 || rsp_tag !== 4'd3) begin
      errors++; $display("FAIL single_rsp got %b/%0d/%0d expected 01/12/3", rsp_valid, rsp_result, rsp_tag); end
    tick();
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL single_drain got %b expected 00", rsp_valid); end
  endtask

  task automatic test_contention;
    logic [1:0]  e;
    logic [31:0] r;
    do_reset();
    set_req(0, 1'b1, 32'd100, 32'd1, OP_SUB, 4'h1);
    set_req(1, 1'b1, 32'd6,   32'd3, OP_AND, 4'h2);
    rsp_ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      e = 2'b01 << (k % 2);
      r = (k % 2 == 0) ? 32'd99 : 32'd2;
      #1;
      checks++; if (req_ready !== e) begin errors++; $display("FAIL contention_grant%0d got %b expected %b", k, req_ready, e); end
      tick();
      checks++; if (rsp_valid !== e || rsp_result !== r || rsp_tag !== TAGW'((k % 2) + 1)) begin
        errors++; $display("FAIL contention_rsp%0d got %b/%0d/%0d expected %b/%0d/%0d", k, rsp_valid, rsp_result, rsp_tag, e, r, (k % 2) + 1); end
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure;
    do_reset();
    set_req(1, 1'b1, 32'd10, 32'd3, OP_SUB, 4'd5);
    rsp_ready = 2'b00;
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL bp_first_grant got %b expected 10", req_ready); end
    tick();
    req_valid[1] = 1'b0;
    set_req(0, 1'b1, 32'd1, 32'd2, OP_ADD, 4'd1);
    rsp_ready = 2'b01;  // non-owner ready must be ignored
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (req_ready !== 2'b00 || rsp_valid !== 2'b10 || rsp_result !== 32'd7 || rsp_tag !== 4'd5) begin
        errors++; $display("FAIL bp_hold%0d got ready=%b valid=%b res=%0d tag=%0d expected 00/10/7/5", k, req_ready, rsp_valid, rsp_result, rsp_tag); end
      tick();
    end
    rsp_ready = 2'b10;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL bp_release_grant got %b expected 01", req_ready); end
    tick();
    req_valid = '0;
    checks++; if (rsp_valid !== 2'b01 || rsp_result !== 32'd3 || rsp_tag !== 4'd1) begin
      errors++; $display("FAIL bp_release_rsp got %b/%0d/%0d expected 01/3/1", rsp_valid, rsp_result, rsp_tag); end
  endtask

  task automatic test_drain_accept;
    do_reset();
    set_req(0, 1'b1, 32'd20, 32'd22, OP_ADD, 4'd2);
    rsp_ready = 2'b11;
    tick();
    req_valid[0] = 1'b0;
    set_req(1, 1'b1, 32'h0000_F0F0, 32'h0000_0FF0, OP_XOR, 4'd9);
    checks++; if (rsp_valid !== 2'b01 || rsp_result !== 32'd42) begin errors++; $display("FAIL da_first got %b/%0d expected 01/42", rsp_valid, rsp_result); end
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL da_grant got %b expected 10", req_ready); end
    tick();
    req_valid = '0;
    checks++; if (rsp_valid !== 2'b10 || rsp_result !== 32'h0000_FF00 || rsp_tag !== 4'd9) begin
      errors++; $display("FAIL da_second got %b/%h/%0d expected 10/0000ff00/9", rsp_valid, rsp_result, rsp_tag); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    set_req(1, 1'b1, 32'd4, 32'd4, OP_ADD, 4'd7);
    rsp_ready = 2'b00;
    tick();
    checks++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL rm_pending got %b expected 10", rsp_valid); end
    reset = 1'b1;
    set_req(0, 1'b1, 32'd8, 32'd1, OP_ADD, 4'd6);
    #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rm_ready_in_reset got %b expected 00", req_ready); end
    tick();
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rm_flush got %b expected 00", rsp_valid); end
    reset = 1'b0;
    rsp_ready = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rm_first_grant got %b expected 01", req_ready); end
    tick();
    req_valid = '0;
    checks++; if (rsp_valid !== 2'b01 || rsp_result !== 32'd9) begin errors++; $display("FAIL rm_rsp got %b/%0d expected 01/9", rsp_valid, rsp_result); end
  endtask

  task automatic test_idle;
    do_reset();
    set_req(0, 1'b0, 32'h11, 32'h22, 4'd3, 4'd1);
    set_req(1, 1'b0, 32'h33, 32'h44, 4'd5, 4'd2);
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (req_ready !== 2'b00 || rsp_valid !== 2'b00) begin errors++; $display("FAIL idle_hs%0d got %b/%b expected 00/00", k, req_ready, rsp_valid); end
      checks++; if (alu_a !== 32'h11 || alu_b !== 32'h22 || alu_op !== 4'd3) begin
        errors++; $display("FAIL idle_alu%0d got %h/%h/%0d expected 11/22/3", k, alu_a, alu_b, alu_op); end
      tick();
    end
  endtask

  task automatic test_random;
    int              last, g, owner, sel;
    bit              m_valid, fire, free;
    logic [31:0]     m_res;
    logic [TAGW-1:0] m_tag;
    logic [NREQ-1:0] hold, e_ready, e_valid;
    do_reset();
    last = NREQ - 1; m_valid = 0; owner = 0; m_res = '0; m_tag = '0; hold = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < NREQ; i++)
        if (!hold[i])
          set_req(i, 1'($urandom_range(0, 9) < 6), $urandom, $urandom, 4'($urandom_range(0, 7)), TAGW'($urandom));
      rsp_ready = NREQ'($urandom);
      #1;
      fire = m_valid && rsp_ready[owner];
      free = !m_valid || fire;
      g = pick(req_valid, last);
      sel = (g < 0) ? 0 : g;
      e_ready = '0;
      if (free && g >= 0) e_ready[g] = 1'b1;
      e_valid = '0;
      if (m_valid) e_valid[owner] = 1'b1;
      checks++; if (req_ready !== e_ready) begin errors++; $display("FAIL rnd_ready c%0d got %b expected %b", cyc, req_ready, e_ready); end
      checks++; if (alu_a !== req_a[sel*32 +: 32] || alu_op !== req_op[sel*4 +: 4]) begin
        errors++; $display("FAIL rnd_alu c%0d got %h/%0d expected requester %0d", cyc, alu_a, alu_op, sel); end
      checks++; if (rsp_valid !== e_valid || (m_valid && (rsp_result !== m_res || rsp_tag !== m_tag))) begin
        errors++; $display("FAIL rnd_rsp c%0d got %b/%h/%h expected %b/%h/%h", cyc, rsp_valid, rsp_result, rsp_tag, e_valid, m_res, m_tag); end
      if (free && g >= 0) begin
        m_valid = 1; owner = g; last = g;
        m_res = alu_f(req_op[g*4 +: 4], req_a[g*32 +: 32], req_b[g*32 +: 32]);
        m_tag = req_tag[g*TAGW +: TAGW];
      end else if (fire) begin
        m_valid = 0;
      end
      hold = req_valid & ~e_ready;
      tick();
    end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_drain_accept();
    test_reset_mid();
    test_idle();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
